// File: rtl/req_encoder_rr.sv
// ---------------------------------------------------------------------------
// req_encoder_rr
//
// Registered request encoder with three run-time selectable arbitration
// modes.  An N_REQ-bit request vector is reduced to a 1-based grant code
// (0 = no grant) one clock after it is sampled.
//
//   MODE 00 / 11 : fixed priority, highest set index wins
//   MODE 01      : strict one-hot; multi-hot inputs raise OUT_ERR and bump
//                  a saturating error counter while the code holds
//   MODE 10      : round-robin, search starts at the rotating pointer
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   RST_N        asynchronous active-low reset
//   EN           encode enable; low holds code, pointer and counter
//   MODE[1:0]    arbitration mode, sampled every cycle
//   CLR_ERR      synchronous clear of OUT_ERR_CNT (honoured even when EN=0)
//   IN_REQ       request vector, bit i = request i
//   OUT_CODE     registered grant code, i+1 for request i, 0 for none
//   OUT_VALID    one-cycle pulse per accepted grant
//   OUT_ERR      one-cycle pulse on a multi-hot request in strict mode
//   OUT_ERR_CNT  saturating count of OUT_ERR events
//
// Parameters
//   N_REQ   number of requesters, 2..15
//   CODE_W  grant code width, 2**CODE_W must exceed N_REQ
//   ERR_W   error counter width
// ---------------------------------------------------------------------------
module req_encoder_rr #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned CODE_W = 3,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic              CLR_ERR,
    input  logic [N_REQ-1:0]  IN_REQ,
    output logic [CODE_W-1:0] OUT_CODE,
    output logic              OUT_VALID,
    output logic              OUT_ERR,
    output logic [ERR_W-1:0]  OUT_ERR_CNT
);

    typedef enum logic [1:0] {
        MODE_FIXED     = 2'b00,
        MODE_STRICT    = 2'b01,
        MODE_RR        = 2'b10,
        MODE_FIXED_ALT = 2'b11
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(MODE);

    // Round-robin pointer; always kept in 0..N_REQ-1.
    logic [CODE_W-1:0] ptr_q;

    // -----------------------------------------------------------------------
    // Fixed priority: highest set index. Also serves as the index in strict
    // mode, where a legal request has exactly one bit set.
    // -----------------------------------------------------------------------
    logic              fp_hit;
    logic [CODE_W-1:0] fp_idx;

    always_comb begin
        fp_hit = 1'b0;
        fp_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (IN_REQ[i]) begin
                fp_hit = 1'b1;
                fp_idx = CODE_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Strict one-hot classification: clearing the lowest set bit leaves a
    // non-zero vector only when two or more bits were set.
    // -----------------------------------------------------------------------
    logic oh_any;
    logic oh_multi;

    assign oh_any   = |IN_REQ;
    assign oh_multi = (IN_REQ & (IN_REQ - {{(N_REQ-1){1'b0}}, 1'b1})) != '0;

    // -----------------------------------------------------------------------
    // Round-robin: rotate the request vector right by the pointer so the
    // search always starts at bit 0, find the lowest set bit, then map the
    // offset back to an absolute index modulo N_REQ.
    // -----------------------------------------------------------------------
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               rr_hit;
    logic [CODE_W-1:0]  rr_idx;
    logic [CODE_W-1:0]  rr_ptr_nxt;
    int unsigned        rr_off;
    int unsigned        rr_abs;

    assign req_dbl = {IN_REQ, IN_REQ} >> ptr_q;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        rr_hit = 1'b0;
        rr_off = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (req_rot[k] && !rr_hit) begin
                rr_hit = 1'b1;
                rr_off = k;
            end
        end
        rr_abs = 32'(ptr_q) + rr_off;
        if (rr_abs >= N_REQ) begin
            rr_abs = rr_abs - N_REQ;
        end
        rr_idx = CODE_W'(rr_abs);
        if (rr_idx == CODE_W'(N_REQ - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = rr_idx + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state for code / valid / error / pointer
    // -----------------------------------------------------------------------
    logic [CODE_W-1:0] code_d;
    logic              valid_d;
    logic              err_d;
    logic [CODE_W-1:0] ptr_d;

    always_comb begin
        code_d  = OUT_CODE;
        valid_d = 1'b0;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        if (EN) begin
            unique case (mode)
                MODE_STRICT: begin
                    if (oh_multi) begin
                        err_d = 1'b1;
                    end else if (oh_any) begin
                        code_d  = fp_idx + 1'b1;
                        valid_d = 1'b1;
                    end
                end
                MODE_RR: begin
                    if (rr_hit) begin
                        code_d  = rr_idx + 1'b1;
                        valid_d = 1'b1;
                        ptr_d   = rr_ptr_nxt;
                    end else begin
                        code_d = '0;
                    end
                end
                MODE_FIXED, MODE_FIXED_ALT: begin
                    if (fp_hit) begin
                        code_d  = fp_idx + 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        code_d = '0;
                    end
                end
                default: begin
                    code_d = OUT_CODE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_CODE  <= '0;
            OUT_VALID <= 1'b0;
            OUT_ERR   <= 1'b0;
            ptr_q     <= '0;
        end else begin
            OUT_CODE  <= code_d;
            OUT_VALID <= valid_d;
            OUT_ERR   <= err_d;
            ptr_q     <= ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating error counter; a clear on the same edge as an error wins.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_ERR_CNT <= '0;
        end else if (CLR_ERR) begin
            OUT_ERR_CNT <= '0;
        end else if (err_d && (OUT_ERR_CNT != '1)) begin
            OUT_ERR_CNT <= OUT_ERR_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_req_encoder_rr.sv
module tb_req_encoder_rr;

    logic       CLK     = 1'b0;
    logic       RST_N   = 1'b0;
    logic       EN      = 1'b0;
    logic [1:0] MODE    = 2'b00;
    logic       CLR_ERR = 1'b0;
    logic [3:0] IN_REQ  = 4'b0000;

    logic [2:0] code_a;
    logic       valid_a;
    logic       err_a;
    logic [7:0] cnt_a;

    logic [2:0] code_b;
    logic       valid_b;
    logic       err_b;
    logic [1:0] cnt_b;

    // Unit A: default 8-bit counter. Unit B: 2-bit counter for saturation.
    req_encoder_rr #(.N_REQ(4), .CODE_W(3), .ERR_W(8)) dut_a (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EN          (EN),
        .MODE        (MODE),
        .CLR_ERR     (CLR_ERR),
        .IN_REQ      (IN_REQ),
        .OUT_CODE    (code_a),
        .OUT_VALID   (valid_a),
        .OUT_ERR     (err_a),
        .OUT_ERR_CNT (cnt_a)
    );

    req_encoder_rr #(.N_REQ(4), .CODE_W(3), .ERR_W(2)) dut_b (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EN          (EN),
        .MODE        (MODE),
        .CLR_ERR     (CLR_ERR),
        .IN_REQ      (IN_REQ),
        .OUT_CODE    (code_b),
        .OUT_VALID   (valid_b),
        .OUT_ERR     (err_b),
        .OUT_ERR_CNT (cnt_b)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] code;
        logic       valid;
        logic       err;
        logic [7:0] cnt_a;
        logic [7:0] cnt_b;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic rst_check(input string nm);
        chk({nm, ".code_a"},  32'(code_a),  0);
        chk({nm, ".valid_a"}, 32'(valid_a), 0);
        chk({nm, ".err_a"},   32'(err_a),   0);
        chk({nm, ".cnt_a"},   32'(cnt_a),   0);
        chk({nm, ".code_b"},  32'(code_b),  0);
        chk({nm, ".valid_b"}, 32'(valid_b), 0);
        chk({nm, ".err_b"},   32'(err_b),   0);
        chk({nm, ".cnt_b"},   32'(cnt_b),   0);
    endtask

    // Drive one cycle of stimulus and queue the response expected after
    // the next rising edge.
    task automatic step(input string nm, input logic en, input logic [1:0] mode,
                        input logic clr, input logic [3:0] req,
                        input int unsigned code, input int unsigned v,
                        input int unsigned e, input int unsigned ca,
                        input int unsigned cb);
        exp_t x;
        @(negedge CLK);
        EN      = en;
        MODE    = mode;
        CLR_ERR = clr;
        IN_REQ  = req;
        x.code  = 8'(code);
        x.valid = v[0];
        x.err   = e[0];
        x.cnt_a = 8'(ca);
        x.cnt_b = 8'(cb);
        exp_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
        @(posedge CLK);
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d responses outstanding, expected 0", nm, exp_q.size());
        end
    endtask

    // Monitor: registered outputs settle just after each rising edge.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                x  = exp_q.pop_front();
                nm = nm_q.pop_front();
                chk({nm, ".code_a"},  32'(code_a),  32'(x.code));
                chk({nm, ".valid_a"}, 32'(valid_a), 32'(x.valid));
                chk({nm, ".err_a"},   32'(err_a),   32'(x.err));
                chk({nm, ".cnt_a"},   32'(cnt_a),   32'(x.cnt_a));
                chk({nm, ".code_b"},  32'(code_b),  32'(x.code));
                chk({nm, ".valid_b"}, 32'(valid_b), 32'(x.valid));
                chk({nm, ".err_b"},   32'(err_b),   32'(x.err));
                chk({nm, ".cnt_b"},   32'(cnt_b),   32'(x.cnt_b));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rot[6];
        int unsigned sat_b[5];
        rot   = '{1, 2, 3, 4, 1, 2};
        sat_b = '{1, 2, 3, 3, 3};

        repeat (2) @(negedge CLK);
        rst_check("reset");
        RST_N = 1'b1;

        // Fixed priority, modes 00 and 11
        step("fp_0101",  1, 2'b00, 0, 4'b0101, 3, 1, 0, 0, 0);
        step("fp_none",  1, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0);
        step("fp11_1010",1, 2'b11, 0, 4'b1010, 4, 1, 0, 0, 0);
        step("fp11_0001",1, 2'b11, 0, 4'b0001, 1, 1, 0, 0, 0);

        // Strict one-hot
        step("oh_0010",  1, 2'b01, 0, 4'b0010, 2, 1, 0, 0, 0);
        step("oh_multi", 1, 2'b01, 0, 4'b0110, 2, 0, 1, 1, 1);
        step("oh_zero",  1, 2'b01, 0, 4'b0000, 2, 0, 0, 1, 1);

        // Round-robin, all requesting, pointer starts at 0
        for (int i = 0; i < 6; i++)
            step("rr_all", 1, 2'b10, 0, 4'b1111, rot[i], 1, 0, 1, 1);
        step("rr_1000a", 1, 2'b10, 0, 4'b1000, 4, 1, 0, 1, 1);
        step("rr_1000b", 1, 2'b10, 0, 4'b1000, 4, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++)
            step("rr_single", 1, 2'b10, 0, 4'b0100, 3, 1, 0, 1, 1);

        // Bring pointer to 2, then stall with EN low
        step("rr_to4",   1, 2'b10, 0, 4'b1111, 4, 1, 0, 1, 1);
        step("rr_to1",   1, 2'b10, 0, 4'b1111, 1, 1, 0, 1, 1);
        step("rr_to2",   1, 2'b10, 0, 4'b1111, 2, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++)
            step("en_hold", 0, 2'b10, 0, 4'b1111, 2, 0, 0, 1, 1);
        step("en_resume",1, 2'b10, 0, 4'b1111, 3, 1, 0, 1, 1);
        step("rr_none",  1, 2'b10, 0, 4'b0000, 0, 0, 0, 1, 1);
        step("rr_wrap",  1, 2'b10, 0, 4'b1001, 4, 1, 0, 1, 1);

        // Clear honoured with EN low; then saturation and clear-vs-increment
        step("clr_en0",  0, 2'b01, 1, 4'b1100, 4, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("err_sat", 1, 2'b01, 0, 4'b1100, 4, 0, 1, 32'(i + 1), sat_b[i]);
        step("clr_wins", 1, 2'b01, 1, 4'b1100, 4, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            step("err_again", 1, 2'b01, 0, 4'b1100, 4, 0, 1, 32'(i + 1), sat_b[i]);
        step("fp_1000",  1, 2'b00, 0, 4'b1000, 4, 1, 0, 5, 3);
        drain("drain1");

        // Asynchronous reset between clock edges
        RST_N = 1'b0;
        #1;
        rst_check("async_reset");
        @(negedge CLK);
        RST_N = 1'b1;
        step("post_rst_rr1", 1, 2'b10, 0, 4'b1111, 1, 1, 0, 0, 0);
        step("post_rst_rr2", 1, 2'b10, 0, 4'b1111, 2, 1, 0, 0, 0);
        drain("drain2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
